// File: rtl/nv_nvdla_mcif_read_ig_os_sched.sv
// MCIF read-ingress scheduler: WRR arbitration of NUM_REQ read streams
// onto one AR path, throttled by an outstanding-read limit.
// Ports:
//   nvdla_core_clk/rstn   clock, async active-low reset
//   req_valid/ready/pd    per-requester request handshake and payload
//   reg2dp_rd_weight      per-requester WRR weight (0 acts as 1)
//   reg2dp_rd_os_cnt      outstanding limit minus 1
//   eg2ig_axi_vld         one read retired by egress
//   sched_req_*           registered granted request to downstream
//   os_cnt/os_full        outstanding count and limit-reached flag
module nv_nvdla_mcif_read_ig_os_sched #(
  parameter int NUM_REQ = 10,
  parameter int PD_W    = 75
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*PD_W-1:0] req_pd,
  input  logic [NUM_REQ*8-1:0]    reg2dp_rd_weight,
  input  logic [7:0]              reg2dp_rd_os_cnt,
  input  logic                    eg2ig_axi_vld,
  output logic                    sched_req_valid,
  input  logic                    sched_req_ready,
  output logic [PD_W-1:0]         sched_req_pd,
  output logic [3:0]              sched_req_id,
  output logic [8:0]              os_cnt,
  output logic                    os_full
);

  logic [3:0] cur;
  logic [7:0] credit;
  logic       load_en;
  logic       grant_en;
  logic       hit;
  logic       found;
  logic [3:0] gnt_id;
  logic [7:0] gnt_w;
  logic [8:0] limit;
  int         idx;

  assign limit    = {1'b0, reg2dp_rd_os_cnt} + 9'd1;
  assign os_full  = (os_cnt >= limit);
  assign load_en  = !sched_req_valid || sched_req_ready;
  assign grant_en = load_en && !os_full && (|req_valid);

  // Stay on the current requester while it has burst credit,
  // otherwise scan forward from cur+1, visiting cur itself last.
  assign hit = req_valid[cur] && (credit != 8'd0);

  always_comb begin
    gnt_id = cur;
    found  = hit;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(cur) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = 4'(idx);
      end
    end
  end

  assign gnt_w = reg2dp_rd_weight[int'(gnt_id)*8 +: 8];

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = grant_en && (int'(gnt_id) == i);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cur    <= 4'(NUM_REQ - 1);
      credit <= 8'd0;
    end else if (grant_en) begin
      cur <= gnt_id;
      if (hit)
        credit <= credit - 8'd1;
      else if (gnt_w == 8'd0)
        credit <= 8'd0;
      else
        credit <= gnt_w - 8'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sched_req_valid <= 1'b0;
      sched_req_pd    <= '0;
      sched_req_id    <= 4'd0;
    end else if (grant_en) begin
      sched_req_valid <= 1'b1;
      sched_req_pd    <= req_pd[int'(gnt_id)*PD_W +: PD_W];
      sched_req_id    <= gnt_id;
    end else if (sched_req_ready) begin
      sched_req_valid <= 1'b0;
    end
  end

  // Count is reserved at grant; a retire with no grant saturates at 0.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      os_cnt <= 9'd0;
    end else if (grant_en && !eg2ig_axi_vld) begin
      os_cnt <= os_cnt + 9'd1;
    end else if (!grant_en && eg2ig_axi_vld) begin
      if (os_cnt != 9'd0) os_cnt <= os_cnt - 9'd1;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_mcif_read_ig_os_sched.sv
// Directed bench for nv_nvdla_mcif_read_ig_os_sched.
// Hand-computed grant orders, throttling, stall and reset cases.
module tb_nv_nvdla_mcif_read_ig_os_sched;
  localparam int N = 10;
  localparam int W = 75;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_pd;
  logic [N*8-1:0] weight = '0;
  logic [7:0]     os_reg = 8'd255;
  logic           ret = 1'b0;
  logic           o_valid;
  logic           o_ready = 1'b0;
  logic [W-1:0]   o_pd;
  logic [3:0]     o_id;
  logic [8:0]     os_cnt;
  logic           os_full;
  logic [W-1:0]   exp_pd [N];

  int errs = 0;
  int checks = 0;

  nv_nvdla_mcif_read_ig_os_sched #(.NUM_REQ(N), .PD_W(W)) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_pd           (req_pd),
    .reg2dp_rd_weight (weight),
    .reg2dp_rd_os_cnt (os_reg),
    .eg2ig_axi_vld    (ret),
    .sched_req_valid  (o_valid),
    .sched_req_ready  (o_ready),
    .sched_req_pd     (o_pd),
    .sched_req_id     (o_id),
    .os_cnt           (os_cnt),
    .os_full          (os_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
    ret = 1'b0;
    o_ready = 1'b0;
    weight = '0;
    os_reg = 8'd255;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    int ids1 [8];
    logic [W-1:0] hold_pd;
    ids1 = '{0, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < N; i++) begin
      exp_pd[i] = {4'(i), 71'(i * 32'h9E3779B1 + 7)};
      req_pd[i*W +: W] = exp_pd[i];
    end

    // Reset state
    #2;
    check("rst_valid", 128'(o_valid), 128'(0));
    check("rst_pd", 128'(o_pd), 128'(0));
    check("rst_id", 128'(o_id), 128'(0));
    check("rst_cnt", 128'(os_cnt), 128'(0));
    check("rst_full", 128'(os_full), 128'(0));
    check("rst_rdy", 128'(req_ready), 128'(0));

    // 1: weights 3/1
    do_reset();
    weight[0 +: 8] = 8'd3;
    weight[8 +: 8] = 8'd1;
    o_ready = 1'b1;
    req_valid = 10'b11;
    #1;
    check("t1_rdy0", 128'(req_ready), 128'(10'b01));
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t1_id%0d", k), 128'(o_id), 128'(ids1[k]));
      check($sformatf("t1_pd%0d", k), 128'(o_pd),
            128'(exp_pd[ids1[k]]));
    end
    check("t1_cnt", 128'(os_cnt), 128'(8));

    // 2: all valid, weights 0 -> plain round robin
    do_reset();
    o_ready = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 11; k++) begin
      tick();
      check($sformatf("t2_id%0d", k), 128'(o_id), 128'(k % N));
      check($sformatf("t2_v%0d", k), 128'(o_valid), 128'(1));
    end

    // 3: limit 2, then one retire
    do_reset();
    os_reg = 8'd1;
    o_ready = 1'b1;
    req_valid = 10'b100;
    tick();
    check("t3_cnt1", 128'(os_cnt), 128'(1));
    tick();
    check("t3_cnt2", 128'(os_cnt), 128'(2));
    check("t3_full", 128'(os_full), 128'(1));
    check("t3_rdy", 128'(req_ready), 128'(0));
    tick();
    check("t3_vclr", 128'(o_valid), 128'(0));
    check("t3_hold", 128'(os_cnt), 128'(2));
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("t3_dec", 128'(os_cnt), 128'(1));
    check("t3_nfull", 128'(os_full), 128'(0));
    check("t3_rdy2", 128'(req_ready), 128'(10'b100));
    tick();
    check("t3_v3", 128'(o_valid), 128'(1));
    check("t3_cnt3", 128'(os_cnt), 128'(2));
    check("t3_full3", 128'(os_full), 128'(1));

    // 4: downstream stall for 5 cycles
    do_reset();
    req_valid = 10'b0000101000;
    tick();
    check("t4_id", 128'(o_id), 128'(3));
    hold_pd = o_pd;
    check("t4_pd", 128'(hold_pd), 128'(exp_pd[3]));
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t4_sid%0d", k), 128'(o_id), 128'(3));
      check($sformatf("t4_spd%0d", k), 128'(o_pd), 128'(hold_pd));
      check($sformatf("t4_srdy%0d", k), 128'(req_ready), 128'(0));
    end
    check("t4_cnt", 128'(os_cnt), 128'(1));
    o_ready = 1'b1;
    #1;
    check("t4_rel", 128'(req_ready), 128'(10'b0000100000));
    tick();
    check("t4_id2", 128'(o_id), 128'(5));
    check("t4_pd2", 128'(o_pd), 128'(exp_pd[5]));

    // 5: grant and retire together at limit-1
    do_reset();
    os_reg = 8'd3;
    o_ready = 1'b1;
    req_valid = 10'b1;
    tick();
    tick();
    tick();
    check("t5_cnt", 128'(os_cnt), 128'(3));
    check("t5_nf", 128'(os_full), 128'(0));
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("t5_same", 128'(os_cnt), 128'(3));
    check("t5_nf2", 128'(os_full), 128'(0));
    check("t5_v", 128'(o_valid), 128'(1));

    // 6: async reset mid-operation
    do_reset();
    o_ready = 1'b1;
    req_valid = 10'b1100000000;
    for (int k = 0; k < 5; k++) tick();
    check("t6_pre", 128'(os_cnt), 128'(5));
    check("t6_prev", 128'(o_valid), 128'(1));
    #2;
    rstn = 1'b0;
    #1;
    check("t6_v", 128'(o_valid), 128'(0));
    check("t6_cnt", 128'(os_cnt), 128'(0));
    check("t6_id", 128'(o_id), 128'(0));
    check("t6_pd", 128'(o_pd), 128'(0));
    req_valid = 10'b0011010000;
    tick();
    rstn = 1'b1;
    tick();
    check("t6_first", 128'(o_id), 128'(4));
    check("t6_cnt1", 128'(os_cnt), 128'(1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
